// File: rtl/single_fetch.sv
// Instruction-fetch stage: owns the PC, presents it to instruction memory and
// selects the next PC from sequential, branch and jump sources, with stall and halt.
module single_fetch #(
  parameter int unsigned          PC_W     = 9,
  parameter logic [PC_W-1:0]      RESET_PC = 9'h1FF,
  parameter logic [PC_W-1:0]      START_PC = 9'h000,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  input  logic [31:0]      boff,
  input  logic             jump,
  input  logic [25:0]      jaddr,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_data,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1,
  output logic [31:0]      instr,
  output logic             valid,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic [PC_W-1:0]  jump_target;
  logic [PC_W-1:0]  branch_target;
  logic             unused_bits;

  // Only the low PC_W bits of the offset and target fields address the memory.
  assign unused_bits   = ^{boff[31:PC_W], jaddr[25:PC_W]};
  assign jump_target   = jaddr[PC_W-1:0];
  assign branch_target = pc_plus1 + boff[PC_W-1:0];

  assign pc_plus1  = pc_reg + PC_ONE;
  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign valid     = (state_reg == ST_RUN);
  assign halted    = (state_reg == ST_HALT);
  assign instr     = valid ? imem_data : 32'h0;
  assign retired   = retired_reg;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    case (state_reg)
      ST_BOOT: begin
        pc_next    = START_PC;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (retired_reg != {CNT_W{1'b1}}) begin
            retired_next = retired_reg + CNT_ONE;
          end
          // A jump onto itself is the halt idiom; the PC simply stays put.
          if (jump) begin
            if (jump_target == pc_reg) begin
              state_next = ST_HALT;
            end else begin
              pc_next = jump_target;
            end
          end else if (branch && zero) begin
            pc_next = branch_target;
          end else begin
            pc_next = pc_plus1;
          end
        end
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_BOOT;
      pc_reg      <= RESET_PC;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
    end
  end

endmodule

// File: tb/tb_single_fetch.sv
// Scoreboard bench for single_fetch: a behavioural model pushes the expected
// fetch state after every clock/reset event and a monitor compares it to the DUT.
module tb_single_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
  logic [31:0] boff = '0;
  logic [25:0] jaddr = '0;
  logic [8:0]  imem_addr;
  logic [31:0] imem_data;
  logic [8:0]  pc, pc_plus1;
  logic [31:0] instr;
  logic        valid, halted;
  logic [31:0] retired;

  logic [31:0] imem [512];
  assign imem_data = imem[imem_addr];

  single_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
    .boff(boff), .jump(jump), .jaddr(jaddr), .imem_addr(imem_addr),
    .imem_data(imem_data), .pc(pc), .pc_plus1(pc_plus1), .instr(instr),
    .valid(valid), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  pc;
    logic        valid;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  exp_t q[$];
  event check_now;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: mode 0 = waiting for first fetch, 1 = fetching, 2 = stopped.
  int          m_mode = 0;
  int          m_pc   = 511;
  logic [31:0] m_ret  = '0;

  function automatic exp_t snap();
    exp_t e;
    e.pc      = 9'(m_pc);
    e.valid   = (m_mode == 1);
    e.halted  = (m_mode == 2);
    e.retired = m_ret;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = 0;
        m_pc   = 511;
        m_ret  = '0;
        q.push_back(snap());
        ->check_now;
      end else begin
        if (m_mode == 0) begin
          m_pc   = 0;
          m_mode = 1;
        end else if (m_mode == 1 && !stall) begin
          if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
          if (jump) begin
            if (int'(jaddr % 26'd512) == m_pc) m_mode = 2;
            else m_pc = int'(jaddr % 26'd512);
          end else if (branch && zero) begin
            m_pc = ((m_pc + 1 + $signed(boff)) % 512 + 512) % 512;
          end else begin
            m_pc = (m_pc + 1) % 512;
          end
        end
        q.push_back(snap());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk or check_now);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        $display("t=%0t pc=%h valid=%b halted=%b retired=%0d instr=%h",
                 $time, pc, valid, halted, retired, instr);
        check("pc", 32'(pc), 32'(e.pc));
        check("imem_addr", 32'(imem_addr), 32'(e.pc));
        check("pc_plus1", 32'(pc_plus1), 32'(9'(e.pc + 9'd1)));
        check("valid", 32'(valid), 32'(e.valid));
        check("halted", 32'(halted), 32'(e.halted));
        check("retired", retired, e.retired);
        check("instr", instr, e.valid ? imem[e.pc] : 32'h0);
      end
    end
  end

  task automatic drive(input logic s, input logic b, input logic z, input logic [31:0] bo,
                       input logic j, input logic [25:0] ja);
    @(negedge clk);
    stall = s; branch = b; zero = z; boff = bo; jump = j; jaddr = ja;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  task automatic chk_pc(input string name, input int exp);
    @(posedge clk);
    #1;
    check(name, 32'(pc), 32'(exp));
  endtask

  task automatic jump_to(input int target);
    if (m_pc != target) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'(target));
  endtask

  task automatic reset_pulse();
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_pc", 32'(pc), 32'h1FF);
    check("rst_retired", retired, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    #1 rst = 1'b0;
    chk_pc("restart_pc", 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0;
    for (int i = 0; i < 512; i++) imem[i] = $urandom;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) chk_pc("boot_seq", i);
    check("boot_retired", retired, 32'd3);
    check("boot_valid", 32'(valid), 32'h1);

    jump_to(5);
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 26'h0);
    chk_pc("branch_back", 3);
    jump_to(5);
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b0, 26'h0);
    chk_pc("branch_not_taken", 6);
    jump_to(16);
    drive(1'b0, 1'b1, 1'b1, 32'h5, 1'b1, 26'h0040);
    chk_pc("jump_priority", 64);

    jump_to(32);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 26'h100);
      if (i == 0) r0 = m_ret;
      chk_pc("stall_hold", 32);
      check("stall_retired", retired, r0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h100);
    chk_pc("stall_release", 256);
    check("stall_release_ret", retired, r0 + 32'd1);

    jump_to(511);
    idle();
    chk_pc("wrap", 0);

    jump_to(48);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h030);
    chk_pc("halt_pc", 48);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_valid", 32'(valid), 32'h0);
    check("halt_instr", instr, 32'h0);
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom), 1'b1, 1'b1, 32'h7, 1'b1, 26'($urandom));
      chk_pc("halt_frozen", 48);
    end
    reset_pulse();

    for (int i = 0; i < 5; i++) idle();
    reset_pulse();

    for (int i = 0; i < 400; i++) begin
      logic [25:0] ja;
      logic        j;
      if (i % 80 == 79) begin
        reset_pulse();
      end else begin
        j  = ($urandom_range(0, 9) == 0);
        ja = 26'($urandom);
        if (j && $urandom_range(0, 9) == 0) ja[8:0] = 9'(m_pc);
        drive($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
              32'($urandom_range(0, 40)) - 32'd20, j, ja);
      end
    end

    idle();
    idle();
    @(negedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/single_fetch.md
Name: single_fetch

Overview:
- Instruction-fetch stage that owns the program counter of the single-cycle CPU.
- Each cycle it presents the 9-bit word address to instruction memory and forwards the returned word to decode and control.
- It computes the next PC from sequential, branch and jump sources, and supports stall and halt.
- It also keeps a retired-instruction counter for debug.

Parameters:
- PC_W, 9, PC and instruction-memory word-address width (512 words)
- RESET_PC, 9'h1FF, PC value while rst is asserted
- START_PC, 9'h000, first fetched address after reset
- CNT_W, 32, retired-counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  hold the PC this cycle
- branch  in  1  Branch from control decode
- zero  in  1  ALU zero flag
- boff  in  32  sign-extended branch offset in words; low PC_W bits used
- jump  in  1  Jump from control decode
- jaddr  in  26  instruction target field; low PC_W bits used
- imem_addr  out  PC_W  instruction-memory address
- imem_data  in  32  instruction-memory read data (combinational)
- pc  out  PC_W  current PC
- pc_plus1  out  PC_W  pc+1 mod 2^PC_W
- instr  out  32  fetched instruction; 32'h0 (NOP) when valid=0
- valid  out  1  instr is a real instruction
- halted  out  1  fetch halted
- retired  out  CNT_W  count of instructions retired

Behaviour:
- Reset values (async, while rst=1):
  - pc=RESET_PC, state=BOOT
  - valid=0, halted=0, retired=0
  - instr=0, pc_plus1=START_PC when RESET_PC=1FF
- Combinational paths:
  - imem_addr=pc.
  - pc_plus1=pc+1, wrapping at 1FF->000.
  - instr=valid ? imem_data : 0.
- States:
  - BOOT: valid=0. The first clk edge after rst falls sets pc<=START_PC and state<=RUN, regardless of stall.
  - RUN: valid=1.
  - HALT: valid=0, halted=1.
- RUN, stall=1: pc, state and retired hold. branch, zero and jump are ignored.
- RUN, stall=0, at each rising edge:
  - retired<=retired+1, saturating at all-ones.
  - Next-PC priority:
    - jump=1: pc<=jaddr[PC_W-1:0].
    - else branch=1 and zero=1: pc<=pc_plus1+boff[PC_W-1:0], modulo 2^PC_W. Backward offsets wrap correctly.
    - else pc<=pc_plus1.
  - branch=1 with zero=0 is sequential.
  - jump=1 and branch=1 together: jump wins.
- Halt detection:
  - Trigger: RUN, stall=0, jump=1 and jaddr[PC_W-1:0]==pc.
  - Action: state<=HALT, pc holds, retired increments once.
- HALT:
  - pc and retired frozen.
  - All inputs ignored until rst.
- Reset mid-operation: state, pc and counters return to reset values immediately (asynchronously), not at the next edge.
- Latency:
  - A redirect decided in cycle N is visible on pc/imem_addr in cycle N+1.
  - No delay slot.
- No X propagation: all registers have reset values.

Test Plan:
- Assert rst, release, run 4 cycles with no control inputs -> pc: 1FF, 000, 001, 002, 003. valid goes 0->1 at pc=000. retired=3 after 4 edges.
- At pc=005, branch=1, zero=1, boff=32'hFFFFFFFD -> next pc=003. Same at pc=005 with zero=0 -> next pc=006.
- At pc=010, jump=1, jaddr=26'h0040, branch=1, zero=1, boff=5 -> next pc=040 (jump priority).
- At pc=020, hold stall=1 for 3 cycles with jump=1, jaddr=0x100 -> pc stays 020 and retired unchanged. Then stall=0 -> pc=100 and retired+1.
- Sequence reaching pc=1FF with no redirect -> next pc=000. At pc=030 jump to 030 -> halted=1, valid=0, instr=0, pc frozen over 10 cycles.
- While halted, or mid-run between edges, pulse rst for 2 ns -> pc=1FF, retired=0, halted=0 immediately. After release, fetch restarts from 000.
